// File: rtl/usr_pkg.sv
// Shared op-codes, burst FSM states and op classification helpers for the
// parametrised universal shift register (usr_param).
package usr_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROTL = 3'b100;
  localparam logic [2:0] OP_ROTR = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Only genuine shift/rotate ops may run as an autonomous burst.
  function automatic logic is_burst_op(input logic [2:0] op);
    logic ok;
    case (op)
      OP_SHL, OP_SHR, OP_ROTL, OP_ROTR, OP_ASR: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Left-moving ops expose the MSB end on SO; all others expose the LSB end.
  function automatic logic so_from_msb(input logic [2:0] op);
    logic msb;
    case (op)
      OP_SHL, OP_ROTL: msb = 1'b1;
      default:         msb = 1'b0;
    endcase
    return msb;
  endfunction

endpackage

// File: rtl/usr_shift_core.sv
// Combinational next-value function of the shift register; shared by the
// idle (direct op) path and the burst path of usr_param.
module usr_shift_core
  import usr_pkg::*;
#(
  parameter int W    = 8,
  parameter int STEP = 1
) (
  input  logic [W-1:0]    po_i,
  input  logic [2:0]      op_i,
  input  logic [STEP-1:0] si_l_i,
  input  logic [STEP-1:0] si_r_i,
  input  logic [W-1:0]    pi_i,
  output logic [W-1:0]    nxt_o
);

  // Next register value for every op-code.
  always_comb begin
    nxt_o = po_i;
    case (op_i)
      OP_HOLD: nxt_o = po_i;
      OP_SHL:  nxt_o = {po_i[W-1-STEP:0], si_r_i};
      OP_SHR:  nxt_o = {si_l_i, po_i[W-1:STEP]};
      OP_LOAD: nxt_o = pi_i;
      OP_ROTL: nxt_o = {po_i[W-1-STEP:0], po_i[W-1:W-STEP]};
      OP_ROTR: nxt_o = {po_i[STEP-1:0], po_i[W-1:STEP]};
      OP_ASR:  nxt_o = {{STEP{po_i[W-1]}}, po_i[W-1:STEP]};
      OP_CLR:  nxt_o = {W{1'b0}};
      default: nxt_o = po_i;
    endcase
  end

endmodule

// File: rtl/usr_param.sv
// Parametrised universal shift register with autonomous burst mode.
// Optional registered even-parity output enabled by macro USR_PARITY_EN.
module usr_param
  import usr_pkg::*;
#(
  parameter int W     = 8,
  parameter int STEP  = 1,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  input  logic [W-1:0]     PI,
  input  logic [STEP-1:0]  SI_L,
  input  logic [STEP-1:0]  SI_R,
  output logic [W-1:0]     PO,
  output logic [STEP-1:0]  SO,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     po_q, po_d;
  logic             done_q, done_d;
  logic [2:0]       core_op;
  logic [2:0]       eff_op;

  usr_shift_core #(
    .W    (W),
    .STEP (STEP)
  ) u_core (
    .po_i   (po_q),
    .op_i   (core_op),
    .si_l_i (SI_L),
    .si_r_i (SI_R),
    .pi_i   (PI),
    .nxt_o  (po_d)
  );

  // Burst FSM next state, counter and op selection for the shift core.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    done_d  = 1'b0;
    core_op = OP_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Start wins over a direct op: nothing shifts on the request edge.
          if ((cnt != {CNT_W{1'b0}}) && is_burst_op(op)) begin
            state_d = ST_RUN;
            cnt_d   = cnt;
            op_d    = op;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          core_op = op;
        end
      end
      ST_RUN: begin
        core_op = op_q;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          op_d    = OP_HOLD;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        op_d    = OP_HOLD;
      end
    endcase
  end

  // State, counter, latched op, data and done registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= OP_HOLD;
      po_q    <= {W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      po_q    <= po_d;
      done_q  <= done_d;
    end
  end

  // Serial-out end follows the op actually in effect this cycle.
  always_comb begin
    eff_op = (state_q == ST_RUN) ? op_q : op;
    if (so_from_msb(eff_op)) begin
      SO = po_q[W-1:W-STEP];
    end else begin
      SO = po_q[STEP-1:0];
    end
  end

  assign PO   = po_q;
  assign busy = (state_q == ST_RUN);
  assign done = done_q;

`ifdef USR_PARITY_EN
  logic parity_q;

  function automatic logic calc_parity(input logic [W-1:0] v);
    return ^v;
  endfunction

  // Even parity of the value PO takes on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= calc_parity(po_d);
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_usr_param.sv
// Directed self-checking bench for usr_param (W=8/STEP=1 and W=8/STEP=2).
module tb_usr_param;

  logic       clk;
  logic       rst;
  logic [2:0] op;
  logic       start;
  logic [3:0] cnt;
  logic [7:0] pi;
  logic       si_l;
  logic       si_r;
  logic [7:0] po;
  logic       so;
  logic       busy;
  logic       done;

  logic [2:0] op2;
  logic       start2;
  logic [3:0] cnt2;
  logic [7:0] pi2;
  logic [1:0] si_l2;
  logic [1:0] si_r2;
  logic [7:0] po2;
  logic [1:0] so2;
  logic       busy2;
  logic       done2;

`ifdef USR_PARITY_EN
  logic       par;
  logic       par2;
`endif

  int vectors;
  int miscompares;

  usr_param #(.W(8), .STEP(1), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .op    (op),
    .start (start),
    .cnt   (cnt),
    .PI    (pi),
    .SI_L  (si_l),
    .SI_R  (si_r),
    .PO    (po),
    .SO    (so),
    .busy  (busy),
    .done  (done)
`ifdef USR_PARITY_EN
    ,
    .parity(par)
`endif
  );

  usr_param #(.W(8), .STEP(2), .CNT_W(4)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .op    (op2),
    .start (start2),
    .cnt   (cnt2),
    .PI    (pi2),
    .SI_L  (si_l2),
    .SI_R  (si_r2),
    .PO    (po2),
    .SO    (so2),
    .busy  (busy2),
    .done  (done2)
`ifdef USR_PARITY_EN
    ,
    .parity(par2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ser_bits;
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; op = 3'b000; start = 1'b0; cnt = 4'd0; pi = 8'h00; si_l = 1'b0; si_r = 1'b0;
    op2 = 3'b000; start2 = 1'b0; cnt2 = 4'd0; pi2 = 8'h00; si_l2 = 2'b00; si_r2 = 2'b00;

    #2 rst = 1'b0;
    #1;
    check("reset_po", 32'(po), 32'h00);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset between edges
    op = 3'b011; pi = 8'hA5;
    tick();
    check("load_a5", 32'(po), 32'hA5);
    #2 rst = 1'b0;
    #1;
    check("async_rst_po", 32'(po), 32'h00);
    check("async_rst_busy", 32'(busy), 32'h0);
    rst = 1'b1; op = 3'b000;
    tick();
    check("hold_after_rst", 32'(po), 32'h00);

    // Directed single-cycle ops
    op = 3'b011; pi = 8'h81;
    tick();
    check("load_81", 32'(po), 32'h81);
    op = 3'b001; si_r = 1'b1; #1;
    check("so_shl", 32'(so), 32'h1);
    tick();
    check("shl", 32'(po), 32'h03);
    op = 3'b101; si_r = 1'b0; #1;
    check("so_rotr", 32'(so), 32'h1);
    tick();
    check("rotr", 32'(po), 32'h81);
    op = 3'b110; si_l = 1'b0; #1;
    check("so_asr", 32'(so), 32'h1);
    tick();
    check("asr", 32'(po), 32'hC0);
    op = 3'b010; si_l = 1'b0; #1;
    check("so_shr", 32'(so), 32'h0);
    tick();
    check("shr", 32'(po), 32'h60);
    op = 3'b111; #1;
    check("so_clr", 32'(so), 32'h0);
    tick();
    check("clr", 32'(po), 32'h00);

    // Burst serialise 0xB4 MSB first, op toggled mid-burst
    op = 3'b011; pi = 8'hB4;
    tick();
    check("load_b4", 32'(po), 32'hB4);
    op = 3'b001; start = 1'b1; cnt = 4'd8; si_r = 1'b0;
    tick();
    check("burst_start_noshift", 32'(po), 32'hB4);
    check("burst_busy_on", 32'(busy), 32'h1);
    start = 1'b0; op = 3'b111;
    ser_bits = 8'b1011_0100;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("burst_busy", 32'(busy), 32'h1);
      check("burst_so", 32'(so), 32'(ser_bits[7-i]));
      tick();
    end
    check("burst_po", 32'(po), 32'h00);
    check("burst_done", 32'(done), 32'h1);
    check("burst_busy_off", 32'(busy), 32'h0);
    op = 3'b000;
    tick();
    check("burst_done_single", 32'(done), 32'h0);

    // cnt=0 request
    op = 3'b011; pi = 8'h5A;
    tick();
    op = 3'b001; start = 1'b1; cnt = 4'd0;
    tick();
    check("cnt0_po", 32'(po), 32'h5A);
    check("cnt0_busy", 32'(busy), 32'h0);
    check("cnt0_done", 32'(done), 32'h1);
    // LOAD with start behaves as cnt=0
    op = 3'b011; pi = 8'hFF; cnt = 4'd5;
    tick();
    check("load_start_po", 32'(po), 32'h5A);
    check("load_start_busy", 32'(busy), 32'h0);
    check("load_start_done", 32'(done), 32'h1);
    start = 1'b0; op = 3'b000;
    tick();
    check("cnt0_done_clear", 32'(done), 32'h0);

    // start while busy is ignored: exactly 3 ROTL shifts
    op = 3'b011; pi = 8'h01;
    tick();
    op = 3'b100; start = 1'b1; cnt = 4'd3;
    tick();
    check("rb_start_po", 32'(po), 32'h01);
    cnt = 4'd5; op = 3'b011; pi = 8'hFF;
    tick();
    check("rb_shift1", 32'(po), 32'h02);
    tick();
    check("rb_shift2", 32'(po), 32'h04);
    check("rb_busy2", 32'(busy), 32'h1);
    start = 1'b0; op = 3'b000;
    tick();
    check("rb_shift3", 32'(po), 32'h08);
    check("rb_busy_off", 32'(busy), 32'h0);
    check("rb_done", 32'(done), 32'h1);
    tick();
    check("rb_hold", 32'(po), 32'h08);
    check("rb_done_clear", 32'(done), 32'h0);

    // STEP=2 instance
    op2 = 3'b011; pi2 = 8'h3C;
    tick();
    check("s2_load", 32'(po2), 32'h3C);
    op2 = 3'b100; #1;
    check("s2_so_rotl1", 32'(so2), 32'h0);
    tick();
    check("s2_rotl1", 32'(po2), 32'hF0);
    check("s2_so_rotl2", 32'(so2), 32'h3);
    tick();
    check("s2_rotl2", 32'(po2), 32'hC3);
    op2 = 3'b000;

`ifdef USR_PARITY_EN
    op = 3'b011; pi = 8'h07;
    tick();
    check("par_load07", 32'(par), 32'h1);
    op = 3'b001; si_r = 1'b1;
    tick();
    check("par_shl_po", 32'(po), 32'h0F);
    check("par_shl", 32'(par), 32'h0);
    op = 3'b000;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
